// File: rtl/mem_stall_injector_pkg.sv
// Shared definitions for the memory wait-state injector: mode and FSM encodings,
// LFSR feedback taps and the saturating statistics increment.
package mem_stall_injector_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_ALWAYS  = 2'd2,
        MODE_RANDOM  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1:
    // the new MSB is the XOR of bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == STAT_MAX) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/mem_stall_injector_lfsr16.sv
// Seeded 16-bit Fibonacci LFSR with enable; exposes only the low OUT_W bits,
// which the injector uses as a random wait count.
module stall_lfsr16
    import mem_stall_injector_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= lfsr16_next(lfsr_q);
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mem_stall_injector.sv
// Wait-state injector between a CPU memory port and a zero-latency memory:
// holds matching accesses off for a programmable number of cycles and keeps statistics.
module mem_stall_injector
    import mem_stall_injector_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned N_REGIONS = 2,
    parameter int unsigned WAIT_W    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    up_req,
    input  logic                    up_we,
    input  logic [ADDR_W-1:0]       up_addr,
    input  logic [XLEN-1:0]         up_wdata,
    output logic [XLEN-1:0]         up_rdata,
    output logic                    up_ready,

    output logic                    dn_req,
    output logic                    dn_we,
    output logic [ADDR_W-1:0]       dn_addr,
    output logic [XLEN-1:0]         dn_wdata,
    input  logic [XLEN-1:0]         dn_rdata,
    input  logic                    dn_ready,

    input  logic [N_REGIONS*ADDR_W-1:0] cfg_base,
    input  logic [N_REGIONS*ADDR_W-1:0] cfg_mask,
    input  logic [N_REGIONS*WAIT_W-1:0] cfg_wait,
    input  logic [N_REGIONS*2-1:0]      cfg_mode,
    input  logic [N_REGIONS-1:0]        cfg_rearm,

    output logic                    stall_active,
    output logic [31:0]             stat_stall_events,
    output logic [31:0]             stat_stall_cycles,
    output logic                    stat_proto_err
);

    state_e              state, state_next;
    logic [WAIT_W-1:0]   cnt, cnt_next;
    logic [N_REGIONS-1:0] armed, armed_next;
    logic [N_REGIONS-1:0] hit;
    logic [N_REGIONS-1:0] sel_onehot;
    logic                sel_oneshot;
    logic [WAIT_W-1:0]   eff_w;
    logic [WAIT_W-1:0]   lfsr_rand;
    logic                new_access;
    logic                start_stall;
    logic                proto_drop;

    // Data path is a straight wire; only the handshake is manipulated.
    assign dn_we    = up_we;
    assign dn_addr  = up_addr;
    assign dn_wdata = up_wdata;
    assign up_rdata = dn_rdata;

    stall_lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (WAIT_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .value (lfsr_rand)
    );

    always_comb begin : region_match
        for (int i = 0; i < N_REGIONS; i++) begin
            hit[i] = ((up_addr ^ cfg_base[i*ADDR_W +: ADDR_W])
                      & cfg_mask[i*ADDR_W +: ADDR_W]) == '0;
        end
    end

    // Scanning from the top down lets the lowest-index hit overwrite the rest.
    always_comb begin : region_select
        sel_onehot  = '0;
        sel_oneshot = 1'b0;
        eff_w       = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_oneshot   = 1'b0;
                case (mode_e'(cfg_mode[2*i +: 2]))
                    MODE_OFF:     eff_w = '0;
                    MODE_ONESHOT: begin
                        eff_w       = armed[i] ? cfg_wait[i*WAIT_W +: WAIT_W] : '0;
                        sel_oneshot = 1'b1;
                    end
                    MODE_ALWAYS:  eff_w = cfg_wait[i*WAIT_W +: WAIT_W];
                    MODE_RANDOM:  eff_w = lfsr_rand & cfg_wait[i*WAIT_W +: WAIT_W];
                    default:      eff_w = '0;
                endcase
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin : fsm_comb
        state_next   = state;
        cnt_next     = cnt;
        dn_req       = 1'b0;
        up_ready     = 1'b0;
        stall_active = 1'b0;
        new_access   = 1'b0;
        start_stall  = 1'b0;
        proto_drop   = 1'b0;

        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (up_req) begin
                        new_access = 1'b1;
                        if (eff_w == '0) begin
                            dn_req   = 1'b1;
                            up_ready = dn_ready;
                        end else begin
                            stall_active = 1'b1;
                            start_stall  = 1'b1;
                            if (eff_w == WAIT_W'(1)) begin
                                state_next = ST_GRANT;
                            end else begin
                                state_next = ST_WAIT;
                                cnt_next   = eff_w - WAIT_W'(1);
                            end
                        end
                    end
                end

                ST_WAIT: begin
                    if (!up_req) begin
                        proto_drop = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stall_active = 1'b1;
                        cnt_next     = cnt - WAIT_W'(1);
                        if (cnt == WAIT_W'(1)) begin
                            state_next = ST_GRANT;
                        end
                    end
                end

                ST_GRANT: begin
                    if (!up_req) begin
                        proto_drop = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        dn_req   = 1'b1;
                        up_ready = dn_ready;
                        if (dn_ready) begin
                            state_next = ST_IDLE;
                        end
                    end
                end

                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A re-arm pulse coinciding with the disarming access keeps the region armed.
    always_comb begin : oneshot_arm
        armed_next = armed;
        if (new_access && sel_oneshot) begin
            armed_next = armed & ~sel_onehot;
        end
        armed_next = armed_next | cfg_rearm;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            armed             <= '1;
            stat_stall_events <= '0;
            stat_stall_cycles <= '0;
            stat_proto_err    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            armed <= armed_next;
            if (start_stall) begin
                stat_stall_events <= sat_inc(stat_stall_events);
            end
            if (stall_active) begin
                stat_stall_cycles <= sat_inc(stat_stall_cycles);
            end
            if (proto_drop) begin
                stat_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stall_injector.sv
// Directed and randomized bench for mem_stall_injector, checked against a
// transaction-level model of region matching, wait counts and statistics.
module tb_mem_stall_injector;

    localparam int          ADDR_W = 32;
    localparam int          XLEN   = 32;
    localparam int          NR     = 2;
    localparam int          WAIT_W = 4;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                 up_req, up_we, up_ready;
    logic [ADDR_W-1:0]    up_addr;
    logic [XLEN-1:0]      up_wdata, up_rdata;
    logic                 dn_req, dn_we, dn_ready;
    logic [ADDR_W-1:0]    dn_addr;
    logic [XLEN-1:0]      dn_wdata, dn_rdata;
    logic [NR*ADDR_W-1:0] cfg_base, cfg_mask;
    logic [NR*WAIT_W-1:0] cfg_wait;
    logic [NR*2-1:0]      cfg_mode;
    logic [NR-1:0]        cfg_rearm;
    logic                 stall_active, stat_proto_err;
    logic [31:0]          stat_stall_events, stat_stall_cycles;

    mem_stall_injector #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .N_REGIONS(NR), .WAIT_W(WAIT_W), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req(up_req), .up_we(up_we), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_rdata(up_rdata), .up_ready(up_ready),
        .dn_req(dn_req), .dn_we(dn_we), .dn_addr(dn_addr), .dn_wdata(dn_wdata),
        .dn_rdata(dn_rdata), .dn_ready(dn_ready),
        .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_wait(cfg_wait),
        .cfg_mode(cfg_mode), .cfg_rearm(cfg_rearm),
        .stall_active(stall_active), .stat_stall_events(stat_stall_events),
        .stat_stall_cycles(stat_stall_cycles), .stat_proto_err(stat_proto_err)
    );

    // Zero-latency memory; dn_ready can be pulled low for a chosen number of request cycles.
    logic [31:0] mem [0:255];
    int          wr_count = 0;
    int          ready_low_done = 0;
    int          ready_low_goal = 0;
    int unsigned cyc_since_rst = 0;

    assign dn_rdata = mem[dn_addr[9:2]];
    assign dn_ready = (ready_low_done >= ready_low_goal);

    always @(posedge clk) begin
        if (rst_n && dn_req) begin
            if (dn_ready && dn_we) begin
                mem[dn_addr[9:2]] <= dn_wdata;
                wr_count          <= wr_count + 1;
            end
            if (!dn_ready) ready_low_done <= ready_low_done + 1;
        end
        cyc_since_rst <= rst_n ? cyc_since_rst + 1 : 0;
    end

    // Reference model state
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [NR-1:0] m_armed;
    int          m_events, m_cycles;
    logic [31:0] exp_mem [int];
    logic [NR-1:0] rearm_next = '0;
    int          poke_at = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // LFSR value after n clock steps from the seed, straight from the polynomial.
    function automatic logic [15:0] ref_lfsr(input int unsigned n);
        logic [15:0] v = SEED;
        logic [15:0] b;
        for (int unsigned k = 0; k < n; k++) begin
            b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
            v = (v >> 1) | (b << 15);
        end
        return v;
    endfunction

    task automatic model_start(input logic [31:0] addr, input logic [NR-1:0] rearm, output int w);
        int m, cw;
        w = 0;
        for (int i = 0; i < NR; i++) begin
            if (((addr ^ cfg_base[i*ADDR_W +: ADDR_W]) & cfg_mask[i*ADDR_W +: ADDR_W]) == 0) begin
                m  = int'(cfg_mode[2*i +: 2]);
                cw = int'(cfg_wait[i*WAIT_W +: WAIT_W]);
                case (m)
                    1: begin w = m_armed[i] ? cw : 0; m_armed[i] = 1'b0; end
                    2: w = cw;
                    3: w = int'(ref_lfsr(cyc_since_rst)) & cw;
                    default: w = 0;
                endcase
                break;
            end
        end
        m_armed = m_armed | rearm;
    endtask

    task automatic set_region(input int i, input logic [31:0] base, input logic [31:0] mask,
                              input logic [1:0] mode, input logic [3:0] w);
        cfg_base[i*ADDR_W +: ADDR_W] = base;
        cfg_mask[i*ADDR_W +: ADDR_W] = mask;
        cfg_mode[2*i +: 2]           = mode;
        cfg_wait[i*WAIT_W +: WAIT_W] = w;
    endtask

    task automatic pulse_rearm(input logic [NR-1:0] bits);
        @(negedge clk);
        cfg_rearm = bits;
        m_armed   = m_armed | bits;
        @(negedge clk);
        cfg_rearm = '0;
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".events"}, stat_stall_events, m_events);
        check({tag, ".cycles"}, stat_stall_cycles, m_cycles);
    endtask

    // One CPU access: hold the request until up_ready, then compare latency and data.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int extra, input string tag);
        int w, waits, sa, early;
        bit done;
        logic [31:0] rd, seen_addr;
        @(negedge clk);
        up_req = 1'b1; up_we = we; up_addr = addr; up_wdata = wdata;
        cfg_rearm = rearm_next;
        ready_low_goal = ready_low_done + extra;
        #1;
        model_start(addr, rearm_next, w);
        rearm_next = '0;
        waits = 0; sa = 0; early = 0; done = 0; rd = '0; seen_addr = '0;
        for (int c = 0; c < 64; c++) begin
            if (stall_active) sa++;
            if (dn_req && stall_active) early++;
            if (up_ready) begin
                rd = up_rdata; seen_addr = dn_addr; done = 1;
                break;
            end
            waits++;
            @(negedge clk);
            cfg_rearm = '0;
            if (waits == poke_at) cfg_wait[WAIT_W-1:0] = 4'd7;
            #1;
        end
        @(posedge clk);
        #1;
        up_req = 1'b0;
        cfg_rearm = '0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".latency"}, waits, w + extra);
        check({tag, ".stall_cycles"}, sa, w);
        check({tag, ".dn_req_in_stall"}, early, 0);
        check({tag, ".dn_addr"}, seen_addr, addr);
        if (!we && exp_mem.exists(int'(addr))) check({tag, ".rdata"}, rd, exp_mem[int'(addr)]);
        if (we) exp_mem[int'(addr)] = wdata;
        if (w > 0) m_events++;
        m_cycles += w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wc, w;
        logic [31:0] a;
        rst_n = 1'b0;
        up_req = 1'b1; up_we = 1'b0; up_addr = 32'h0; up_wdata = '0;
        cfg_base = '0; cfg_mask = '0; cfg_wait = '0; cfg_mode = '0; cfg_rearm = '0;
        m_armed = '1; m_events = 0; m_cycles = 0;

        // Reset: outputs gated even though an access is requested
        repeat (3) @(negedge clk);
        #1;
        check("rst.up_ready", 32'(up_ready), 0);
        check("rst.dn_req", 32'(dn_req), 0);
        check("rst.stall_active", 32'(stall_active), 0);
        @(negedge clk);
        up_req = 1'b0;
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd1, 4'd2);
        set_region(1, 32'h0, 32'h0, 2'd0, 4'd0);
        rst_n = 1'b1;
        #1;
        check_stats("rst");
        check("rst.proto_err", 32'(stat_proto_err), 0);

        // One-shot: first access stalls twice, second passes through
        access(1'b1, 32'h200, 32'd7, 0, "os_sw");
        access(1'b0, 32'h200, 32'd0, 0, "os_lw");
        check_stats("os");
        check("os.writes", wr_count, 1);

        // Always W=3: back-to-back reads, low addresses unstalled
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd2, 4'd3);
        for (int k = 0; k < 3; k++) access(1'b0, 32'h200, 32'd0, 0, "al_rd");
        access(1'b0, 32'h100, 32'd0, 0, "al_fetch");
        check_stats("al");

        // Random mode against the polynomial
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd3, 4'hF);
        for (int k = 0; k < 24; k++) begin
            a = ($urandom_range(0, 3) != 0) ? 32'h200 + 32'($urandom_range(0, 127)) * 4
                                            : 32'($urandom_range(0, 127)) * 4;
            access(1'($urandom_range(0, 1)), a, $urandom, 0, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check_stats("rnd");

        // Overlapping regions: lowest index wins; mid-stall cfg change ignored
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd2, 4'd1);
        set_region(1, 32'h240, 32'hFFFF_FFC0, 2'd2, 4'd5);
        access(1'b0, 32'h240, 32'd0, 0, "ov_w1");
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd2, 4'd3);
        poke_at = 1;
        access(1'b0, 32'h240, 32'd0, 0, "ov_poke");
        poke_at = -1;
        access(1'b0, 32'h240, 32'd0, 0, "ov_w7");
        access(1'b0, 32'h100, 32'd0, 0, "ov_miss");
        check_stats("ov");

        // Protocol violation: drop up_req while stalled
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd2, 4'd5);
        wc = wr_count;
        @(negedge clk);
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h204; up_wdata = 32'hDEAD;
        #1;
        model_start(32'h204, '0, w);
        check("drop.stall0", 32'(stall_active), 1);
        @(negedge clk); #1;
        check("drop.dn_req1", 32'(dn_req), 0);
        @(negedge clk);
        up_req = 1'b0;
        #1;
        check("drop.stall_off", 32'(stall_active), 0);
        @(posedge clk); #1;
        check("drop.proto_err", 32'(stat_proto_err), 1);
        check("drop.no_write", wr_count, wc);
        m_events++;
        m_cycles += 2;
        access(1'b0, 32'h300, 32'd0, 0, "drop_next");
        check("drop.sticky", 32'(stat_proto_err), 1);
        check_stats("drop");

        // Reset mid-stall on an armed one-shot write
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd1, 4'd5);
        pulse_rearm(2'b01);
        wc = wr_count;
        @(negedge clk);
        up_req = 1'b1; up_we = 1'b1; up_addr = 32'h208; up_wdata = 32'hBEEF;
        #1;
        model_start(32'h208, '0, w);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid.up_ready", 32'(up_ready), 0);
        check("rstmid.dn_req", 32'(dn_req), 0);
        check("rstmid.stall_active", 32'(stall_active), 0);
        @(negedge clk);
        @(negedge clk);
        up_req = 1'b0;
        rst_n = 1'b1;
        #1;
        m_events = 0; m_cycles = 0; m_armed = '1;
        check_stats("rstmid");
        check("rstmid.proto_err", 32'(stat_proto_err), 0);
        check("rstmid.no_write", wr_count, wc);
        access(1'b1, 32'h208, 32'h55, 0, "rearmed");

        // Re-arm in the same cycle as the disarming access keeps the region armed
        pulse_rearm(2'b01);
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd1, 4'd2);
        rearm_next = 2'b01;
        access(1'b0, 32'h208, 32'd0, 0, "rearm_same");
        access(1'b0, 32'h208, 32'd0, 0, "rearm_kept");
        access(1'b0, 32'h208, 32'd0, 0, "rearm_gone");

        // Downstream stall in GRANT adds to the injected wait; single write
        set_region(0, 32'h200, 32'hFFFF_FE00, 2'd2, 4'd2);
        wc = wr_count;
        access(1'b1, 32'h210, 32'h1234_5678, 2, "grant_dn");
        check("grant.one_write", wr_count, wc + 1);
        access(1'b0, 32'h210, 32'd0, 0, "grant_rd");
        check_stats("final");
        check("final.proto_err", 32'(stat_proto_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_stall_injector.md
Name: mem_stall_injector

Overview:
- Parametrised wait-state injector between the cpu_top data/instruction memory port and a zero-latency memory model.
- Generalises the fixed single-shot 2-cycle stall used in lw/sw stall benches to N address regions, programmable wait counts and four modes: off, one-shot, always, pseudo-random.
- Collects stall statistics and flags upstream protocol violations.
- Synthesisable; used in benches and FPGA bring-up.

Parameters:
- ADDR_W, 32, address width
- XLEN, 32, data width
- N_REGIONS, 2, number of address regions (1..8)
- WAIT_W, 4, wait-count width; max stall 2^WAIT_W-1 cycles
- LFSR_SEED, 16'hACE1, reset value of 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- up_req  in  1  CPU access request; held with addr/we/wdata stable until up_ready
- up_we  in  1  write enable
- up_addr  in  ADDR_W  byte address
- up_wdata  in  XLEN  write data
- up_rdata  out  XLEN  read data (= dn_rdata, combinational)
- up_ready  out  1  access complete this cycle
- dn_req  out  1  request to memory
- dn_we  out  1  = up_we
- dn_addr  out  ADDR_W  = up_addr
- dn_wdata  out  XLEN  = up_wdata
- dn_rdata  in  XLEN  memory read data
- dn_ready  in  1  memory ready
- cfg_base  in  N_REGIONS*ADDR_W  region i base, slice i
- cfg_mask  in  N_REGIONS*ADDR_W  region i match mask; hit = ((up_addr ^ base) & mask) == 0
- cfg_wait  in  N_REGIONS*WAIT_W  wait count W (random mode: AND-mask)
- cfg_mode  in  N_REGIONS*2  0 OFF, 1 ONESHOT, 2 ALWAYS, 3 RANDOM
- cfg_rearm  in  N_REGIONS  one-cycle pulse re-arms ONESHOT region i
- stall_active  out  1  high while an access is held off
- stat_stall_events  out  32  accesses that received >=1 wait cycle
- stat_stall_cycles  out  32  total cycles with stall_active high
- stat_proto_err  out  1  sticky: up_req dropped while stalled

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, counter 0, all ONESHOT regions armed, LFSR=LFSR_SEED, stats and proto_err 0. While rst_n low: up_ready=0, dn_req=0, stall_active=0.
- LFSR advances every cycle out of reset.
- New access = up_req high in IDLE. Region select: lowest-index hit; no hit -> no stall.
- Effective W: OFF -> 0; ONESHOT -> cfg_wait if armed, else 0; ALWAYS -> cfg_wait; RANDOM -> lfsr[WAIT_W-1:0] & cfg_wait.
- W==0: passthrough in the same cycle (dn_req=up_req, up_ready=dn_ready); zero added latency.
- W>0: up_ready held low and dn_req held low for exactly W cycles, starting with the request cycle. Downstream sees no request during the stall, so a write occurs exactly once.
- W and region index are latched at access start; cfg changes mid-stall do not affect the in-flight access.
- States:
  - IDLE: W>0 -> WAIT with counter=W-1 (W==1 -> GRANT directly). W==0 passthrough; stays IDLE.
  - WAIT: counter decrements; counter==1 -> GRANT.
  - GRANT: dn_req=1, up_ready=dn_ready; dn_ready -> IDLE, else stay (downstream stall is additive).
- ONESHOT disarm happens at access start. cfg_rearm[i] in the same cycle as a disarm wins (region stays armed).
- up_req low in WAIT or GRANT: return to IDLE, access dropped, stat_proto_err<=1 (sticky until reset).
- Stats: events increment at access start with W>0; cycles increment each cycle stall_active is high. Both saturate at 32'hFFFF_FFFF with no wrap.
- stall_active is high in IDLE-with-W>0 and in WAIT.
- Back-to-back: after up_ready, the next cycle with up_req high is a new access and is evaluated again.
- Reset mid-stall: abort immediately; no downstream access.

Decomposition:
- Shared package: mode encodings (MODE_OFF/ONESHOT/ALWAYS/RANDOM), state enum, LFSR tap constant.
- One sub-module: stall_lfsr16 (seeded 16-bit LFSR with enable).
- Region match and priority encode stay inline.

Test Plan:
- Region0 base 0x200, mask 0xFFFFFE00, ONESHOT, W=2; sw 7 to 0x200 then lw from 0x200 -> first data access sees 2 ready-low cycles, lw sees 0; mem[0x200]=7, x3=7; events=1, cycles=2.
- ALWAYS W=3 on region0; three back-to-back reads -> each has exactly 3 stall cycles; events=3, cycles=9; instruction fetches below 0x200 are unstalled.
- RANDOM cfg_wait=4'hF, seed 0xACE1 -> per-access stall equals reference-model LFSR low nibble; W==0 accesses show zero latency.
- Overlapping regions 0 (W=1) and 1 (W=5) both hitting 0x240 -> stall is 1 cycle (lowest index wins); cfg_wait0 changed to 7 mid-stall has no effect.
- Drop up_req during WAIT -> no dn_req, stat_proto_err=1 and sticky; assert rst_n mid-stall -> up_ready=0, stats 0, ONESHOT re-armed.
- dn_ready low 2 cycles during GRANT with W=2 -> total ready latency 4 cycles, a single write committed.
